fetch_queue: RTL and testbench

- Consumer side of the PC index interface: takes the instruction index produced by the program counter each cycle.
- Issues it to the synchronous instruction memory, captures the returned word and buffers it in a small in-order queue.
- Presents buffered instructions to decode with a valid/ready handshake.
- Drives a hold back to the PC when the buffer can accept no more, and discards stale instructions on a redirect (Selecao).

---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 61 ++++++
 tb/tb_fetch_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: PC index, instruction memory and decode handshake bundle.
interface fetch_queue_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] Indice;
    logic                  Selecao;
    logic                  pc_hold;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_en;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] inst_out;
    logic [ADDR_WIDTH-1:0] inst_index;
    logic                  inst_valid;
    logic                  inst_ready;

    modport master (
        input  Indice, Selecao, mem_data, inst_ready,
        output pc_hold, mem_addr, mem_en, inst_out, inst_index, inst_valid
    );

    modport slave (
        output Indice, Selecao, mem_data, inst_ready,
        input  pc_hold, mem_addr, mem_en, inst_out, inst_index, inst_valid
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: buffers instruction memory responses in order for decode, holding the PC when out of credit.
module fetch_queue #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic clock,
    input  logic reset,
    fetch_queue_if.master fq
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] idx_q  [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] pend_idx;
    logic [PW+1:0]         used;
    logic                  push, pop;

    // An in-flight response already owns a slot, so credit counts it too
    assign used           = {1'b0, count} + {{(PW+1){1'b0}}, pending};
    assign fq.pc_hold     = ~fq.Selecao & (used >= (PW+2)'(DEPTH));
    assign fq.mem_en      = reset & (fq.Selecao | ~fq.pc_hold);
    assign fq.mem_addr    = fq.Indice;
    assign fq.inst_valid  = (count != '0) & ~fq.Selecao;
    assign fq.inst_out    = data_q[rd_ptr];
    assign fq.inst_index  = idx_q[rd_ptr];
    assign push           = pending & ~fq.Selecao;
    assign pop            = fq.inst_valid & fq.inst_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            pending  <= 1'b0;
            pend_idx <= '0;
        end else begin
            pending  <= fq.mem_en;
            pend_idx <= fq.Indice;
            if (fq.Selecao) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    data_q[wr_ptr] <= fq.mem_data;
                    idx_q[wr_ptr]  <= pend_idx;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue against hand-traced delivery sequences.
module tb_fetch_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic hold_seen;
    logic [9:0]  dq_idx[$];
    logic [31:0] dq_word[$];

    fetch_queue_if q ();

    fetch_queue dut (.clock(clock), .reset(reset), .fq(q));

    always #5 clock = ~clock;

    // Synchronous instruction memory: word = 0x2000_0000 + address, one cycle later
    always @(posedge clock) if (q.mem_en) q.mem_data <= 32'h2000_0000 + 32'(q.mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        logic h;
        #1;
        h = q.pc_hold;
        if (q.pc_hold) hold_seen = 1'b1;
        if (q.inst_valid && q.inst_ready) begin
            dq_idx.push_back(q.inst_index);
            dq_word.push_back(q.inst_out);
        end
        @(posedge clock);
        #1;
        if (!h) q.Indice = q.Indice + 10'd1;
        q.Selecao = 1'b0;
    endtask

    task automatic restart(input logic [9:0] start, input logic rdy);
        reset = 1'b0;
        #1;
        dq_idx.delete();
        dq_word.delete();
        hold_seen = 1'b0;
        q.Indice = start;
        q.Selecao = 1'b0;
        q.inst_ready = rdy;
        reset = 1'b1;
    endtask

    task automatic check_deliv(input string tag, input int pos, input int base, input int n);
        chk({tag, "_cnt"}, 32'(dq_idx.size() >= pos + n), 32'd1);
        for (int i = 0; i < n; i++)
            if (pos + i < dq_idx.size()) begin
                chk({tag, "_idx"}, 32'(dq_idx[pos+i]), 32'(base + i));
                chk({tag, "_word"}, dq_word[pos+i], 32'h2000_0000 + 32'(base + i));
            end
    endtask

    initial begin
        q.Indice = '0;
        q.Selecao = 1'b0;
        q.inst_ready = 1'b0;
        hold_seen = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(q.inst_valid), 32'd0);
        chk("rst_hold", 32'(q.pc_hold), 32'd0);
        chk("rst_mem_en", 32'(q.mem_en), 32'd0);
        chk("rst_out", q.inst_out, 32'd0);
        chk("rst_index", 32'(q.inst_index), 32'd0);

        restart(10'd0, 1'b1);
        #1;
        chk("t1_mem_en", 32'(q.mem_en), 32'd1);
        chk("t1_addr", 32'(q.mem_addr), 32'd0);
        cyc;
        #1;
        chk("t1_lat_valid0", 32'(q.inst_valid), 32'd0);
        cyc;
        #1;
        chk("t1_lat_valid1", 32'(q.inst_valid), 32'd1);
        chk("t1_head_idx", 32'(q.inst_index), 32'd0);
        repeat (4) cyc;
        check_deliv("t1", 0, 0, 4);
        chk("t1_no_hold", 32'(hold_seen), 32'd0);

        restart(10'd0, 1'b0);
        repeat (4) cyc;
        #1;
        chk("t2_hold", 32'(q.pc_hold), 32'd1);
        chk("t2_mem_en", 32'(q.mem_en), 32'd0);
        chk("t2_head", 32'(q.inst_index), 32'd0);
        cyc;
        #1;
        chk("t2_hold_full", 32'(q.pc_hold), 32'd1);
        q.inst_ready = 1'b1;
        cyc;
        q.inst_ready = 1'b0;
        #1;
        chk("t2_hold_fall", 32'(q.pc_hold), 32'd0);
        chk("t2_addr4", 32'(q.mem_addr), 32'd4);
        chk("t2_head1", 32'(q.inst_index), 32'd1);
        repeat (2) cyc;
        q.inst_ready = 1'b1;
        repeat (8) cyc;
        check_deliv("t2", 0, 0, 6);

        restart(10'd5, 1'b0);
        repeat (3) cyc;
        #1;
        chk("t3_head5", 32'(q.inst_index), 32'd5);
        q.Selecao = 1'b1;
        q.Indice = 10'h100;
        #1;
        chk("t3_sel_valid", 32'(q.inst_valid), 32'd0);
        chk("t3_sel_mem_en", 32'(q.mem_en), 32'd1);
        q.inst_ready = 1'b1;
        cyc;
        #1;
        chk("t3_valid_t1", 32'(q.inst_valid), 32'd0);
        cyc;
        #1;
        chk("t3_valid_t2", 32'(q.inst_valid), 32'd1);
        chk("t3_target", 32'(q.inst_index), 32'h100);
        repeat (4) cyc;
        check_deliv("t3", 0, 'h100, 3);

        restart(10'h20, 1'b0);
        repeat (5) cyc;
        #1;
        chk("t4_hold", 32'(q.pc_hold), 32'd1);
        chk("t4_mem_en0", 32'(q.mem_en), 32'd0);
        q.Selecao = 1'b1;
        q.Indice = 10'h3F0;
        #1;
        chk("t4_sel_mem_en", 32'(q.mem_en), 32'd1);
        chk("t4_sel_hold", 32'(q.pc_hold), 32'd0);
        q.inst_ready = 1'b1;
        repeat (6) cyc;
        check_deliv("t4", 0, 'h3F0, 2);

        restart(10'h40, 1'b0);
        repeat (4) cyc;
        #1;
        chk("t5_pre_valid", 32'(q.inst_valid), 32'd1);
        chk("t5_pre_hold", 32'(q.pc_hold), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_valid", 32'(q.inst_valid), 32'd0);
        chk("t5_hold", 32'(q.pc_hold), 32'd0);
        chk("t5_mem_en", 32'(q.mem_en), 32'd0);
        chk("t5_index", 32'(q.inst_index), 32'd0);
        dq_idx.delete();
        dq_word.delete();
        q.Indice = 10'h80;
        q.inst_ready = 1'b1;
        reset = 1'b1;
        repeat (5) cyc;
        check_deliv("t5", 0, 'h80, 2);

        restart(10'd0, 1'b1);
        for (int i = 0; i < 28; i++) begin
            q.inst_ready = (i % 2 == 0);
            if (i == 12) begin
                q.Selecao = 1'b1;
                q.Indice = 10'h010;
            end
            if (i == 13) begin
                q.Selecao = 1'b1;
                q.Indice = 10'h020;
            end
            cyc;
        end
        check_deliv("t6_pre", 0, 0, 5);
        check_deliv("t6_post", 5, 'h20, 6);
        chk("t6_total", 32'(dq_idx.size()), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
